// File: rtl/bridge_pkg.sv
// Shared AXI encodings, the queued request layout and issue-state names for the
// MemoryBus-to-AXI bridge.
package bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam logic [2:0] SIZE_1B   = 3'd0;
    localparam logic [2:0] SIZE_2B   = 3'd1;
    localparam logic [2:0] SIZE_4B   = 3'd2;
    localparam logic [2:0] SIZE_8B   = 3'd3;
    localparam logic [2:0] SIZE_16B  = 3'd4;
    localparam logic [2:0] SIZE_32B  = 3'd5;
    localparam logic [2:0] SIZE_64B  = 3'd6;
    localparam logic [2:0] SIZE_128B = 3'd7;

    // Request fields are held at their widest supported size; the bridge
    // zero-extends into them and slices back out on issue.
    localparam int REQ_ID_W   = 16;
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 64;

    typedef struct packed {
        logic                  write;
        logic [REQ_ID_W-1:0]   id;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } req_t;

    // WAIT_AW: W already accepted, AW pending. WAIT_W: AW accepted, W pending.
    typedef enum logic [1:0] {
        ISSUE_FRESH   = 2'd0,
        ISSUE_WAIT_AW = 2'd1,
        ISSUE_WAIT_W  = 2'd2
    } issue_state_e;

    function automatic logic [2:0] axi_size(input int bytes);
        case (bytes)
            1:       return SIZE_1B;
            2:       return SIZE_2B;
            4:       return SIZE_4B;
            8:       return SIZE_8B;
            16:      return SIZE_16B;
            32:      return SIZE_32B;
            64:      return SIZE_64B;
            default: return SIZE_128B;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a pushed entry becomes visible at
// the head on the cycle after the push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bus_to_axi_bridge.sv
// Buffered MemoryBus slave to single-beat AXI3 master bridge with independent
// AW/W issue, read/write credit limits, buffered read return and sticky errors.
module bus_to_axi_bridge
    import bridge_pkg::*;
#(
    parameter int BUS_DATA_W = 24,
    parameter int BUS_ID_W   = 8,
    parameter int BUS_ADDR_W = 30,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 6,
    parameter int REQ_DEPTH  = 4,
    parameter int RSP_DEPTH  = 8,
    parameter int MAX_RD     = 8,
    parameter int MAX_WR     = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    msValid,
    input  logic                    msWrite,
    input  logic [BUS_ID_W-1:0]     msID,
    input  logic [BUS_ADDR_W-1:0]   msAddress,
    input  logic [BUS_DATA_W-1:0]   msData,
    output logic                    msTaken,
    output logic                    smValid,
    output logic [BUS_ID_W-1:0]     smID,
    output logic [BUS_DATA_W-1:0]   smData,
    input  logic                    smTaken,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [AXI_ID_W-1:0]     arid,
    output logic [31:0]             araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic [3:0]              arqos,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [AXI_ID_W-1:0]     awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic [3:0]              awqos,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [AXI_ID_W-1:0]     wid,
    output logic [AXI_DATA_W-1:0]   wdata,
    output logic [AXI_DATA_W/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [AXI_ID_W-1:0]     rid,
    input  logic [AXI_DATA_W-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [AXI_ID_W-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    err_clr,
    output logic                    rd_err,
    output logic                    wr_err,
    output logic                    proto_err,
    output logic                    idle,
    output logic [1:0]              dbg_issue_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Once raised, a valid holds with a stable payload until its transfer.

    localparam int OFF   = $clog2(AXI_DATA_W/8);
    localparam int RSP_W = AXI_ID_W + BUS_DATA_W;
    localparam int RDC_W = $clog2(MAX_RD + 1);
    localparam int WRC_W = $clog2(MAX_WR + 1);
    localparam logic [RDC_W-1:0] RD_LIM = RDC_W'(MAX_RD);
    localparam logic [WRC_W-1:0] WR_LIM = WRC_W'(MAX_WR);

    req_t                      req_in;
    req_t                      req_head;
    logic                      req_full;
    logic                      req_empty;
    logic                      req_pop;
    logic [BUS_ADDR_W+OFF-1:0] addr_ext;

    issue_state_e issue_state;
    issue_state_e issue_next;
    logic         aw_done;
    logic         w_done;
    logic         ar_hs;
    logic         aw_hs;
    logic         w_hs;

    logic [RSP_W-1:0] rsp_in;
    logic [RSP_W-1:0] rsp_head;
    logic             rsp_full;
    logic             rsp_empty;
    logic             r_hs;
    logic             b_hs;
    logic             b_orphan;

    logic [RDC_W-1:0] rd_cnt;
    logic [WRC_W-1:0] wr_cnt;
    logic             rd_inc;
    logic             rd_dec;
    logic             wr_inc;
    logic             wr_dec;
    logic             unused_inputs;

    // Acceptance sees only registered FIFO/credit state, never an AXI ready.
    assign msTaken = msValid && !req_full &&
                     (msWrite ? (wr_cnt < WR_LIM) : (rd_cnt < RD_LIM));

    assign addr_ext = (BUS_ADDR_W+OFF)'(msAddress) << OFF;

    always_comb begin
        req_in       = '0;
        req_in.write = msWrite;
        req_in.id    = REQ_ID_W'(msID[AXI_ID_W-1:0]);
        req_in.addr  = REQ_ADDR_W'(addr_ext);
        req_in.data  = REQ_DATA_W'(msData);
    end

    sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (msTaken),
        .push_data (req_in),
        .pop       (req_pop),
        .pop_data  (req_head),
        .full      (req_full),
        .empty     (req_empty)
    );

    assign aw_done = (issue_state == ISSUE_WAIT_W);
    assign w_done  = (issue_state == ISSUE_WAIT_AW);

    assign arvalid = !req_empty && !req_head.write;
    assign awvalid = !req_empty && req_head.write && !aw_done;
    assign wvalid  = !req_empty && req_head.write && !w_done;
    assign wlast   = wvalid;

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    assign arid    = req_head.id[AXI_ID_W-1:0];
    assign awid    = req_head.id[AXI_ID_W-1:0];
    assign wid     = req_head.id[AXI_ID_W-1:0];
    assign araddr  = req_head.addr;
    assign awaddr  = req_head.addr;
    assign wdata   = req_head.data[AXI_DATA_W-1:0];
    assign wstrb   = '1;
    assign arlen   = 4'd0;
    assign awlen   = 4'd0;
    assign arsize  = axi_size(AXI_DATA_W/8);
    assign awsize  = axi_size(AXI_DATA_W/8);
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arlock  = '0;
    assign awlock  = '0;
    assign arcache = '0;
    assign awcache = '0;
    assign arprot  = '0;
    assign awprot  = '0;
    assign arqos   = '0;
    assign awqos   = '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) issue_state <= ISSUE_FRESH;
        else        issue_state <= issue_next;
    end

    // A write head retires once both AW and W have transferred, in any order.
    always_comb begin
        issue_next = issue_state;
        req_pop    = 1'b0;
        if (!req_empty) begin
            if (!req_head.write) begin
                req_pop = ar_hs;
            end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                req_pop    = 1'b1;
                issue_next = ISSUE_FRESH;
            end else if (aw_hs) begin
                issue_next = ISSUE_WAIT_W;
            end else if (w_hs) begin
                issue_next = ISSUE_WAIT_AW;
            end
        end
    end

    assign dbg_issue_state = issue_state;

    assign rready = !rsp_full;
    assign r_hs   = rvalid && rready;
    assign rsp_in = {rid, rdata[BUS_DATA_W-1:0]};

    sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (r_hs),
        .push_data (rsp_in),
        .pop       (smTaken),
        .pop_data  (rsp_head),
        .full      (rsp_full),
        .empty     (rsp_empty)
    );

    assign smValid = !rsp_empty;
    assign smID    = BUS_ID_W'(rsp_head[RSP_W-1 -: AXI_ID_W]);
    assign smData  = rsp_head[BUS_DATA_W-1:0];

    assign bready   = 1'b1;
    assign b_hs     = bvalid && bready;
    assign b_orphan = b_hs && (wr_cnt == '0);

    assign rd_inc = msTaken && !msWrite;
    assign rd_dec = smValid && smTaken && (rd_cnt != '0);
    assign wr_inc = msTaken && msWrite;
    assign wr_dec = b_hs && !b_orphan;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_inc && !rd_dec)      rd_cnt <= rd_cnt + 1'b1;
            else if (!rd_inc && rd_dec) rd_cnt <= rd_cnt - 1'b1;
            if (wr_inc && !wr_dec)      wr_cnt <= wr_cnt + 1'b1;
            else if (!wr_inc && wr_dec) wr_cnt <= wr_cnt - 1'b1;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_err    <= 1'b0;
            wr_err    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            rd_err    <= (r_hs && (rresp != RESP_OKAY)) || (rd_err && !err_clr);
            wr_err    <= (b_hs && (bresp != RESP_OKAY)) || (wr_err && !err_clr);
            proto_err <= (r_hs && !rlast) || b_orphan || (proto_err && !err_clr);
        end
    end

    assign idle = req_empty && rsp_empty && (rd_cnt == '0) && (wr_cnt == '0);

    assign unused_inputs = &{1'b0, msID, bid, rdata, req_head};

endmodule

// File: tb/tb_bus_to_axi_bridge.sv
// Directed bench for bus_to_axi_bridge: single read, skewed AW/W write, read
// credit limit, response back-pressure, sticky errors and mid-write reset.
module tb_bus_to_axi_bridge;

    logic        clk_in;
    logic        rst_in;
    logic        msValid, msWrite;
    logic [7:0]  msID;
    logic [29:0] msAddress;
    logic [23:0] msData;
    logic        msTaken;
    logic        smValid;
    logic [7:0]  smID;
    logic [23:0] smData;
    logic        smTaken;
    logic        arvalid, arready;
    logic [5:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen, arcache, arqos;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        awvalid, awready;
    logic [5:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen, awcache, awqos;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        wvalid, wready;
    logic [5:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        rvalid, rready;
    logic [5:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        bvalid, bready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        err_clr;
    logic        rd_err, wr_err, proto_err, idle;
    logic [1:0]  dbg_issue_state;

    int tests;
    int fails;

    bus_to_axi_bridge dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .msValid(msValid), .msWrite(msWrite), .msID(msID), .msAddress(msAddress),
        .msData(msData), .msTaken(msTaken),
        .smValid(smValid), .smID(smID), .smData(smData), .smTaken(smTaken),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arqos(arqos),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awqos(awqos),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .err_clr(err_clr), .rd_err(rd_err), .wr_err(wr_err),
        .proto_err(proto_err), .idle(idle), .dbg_issue_state(dbg_issue_state)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_req(input logic wr, input logic [7:0] id, input logic [29:0] addr,
                           input logic [23:0] data);
        msValid   = 1'b1;
        msWrite   = wr;
        msID      = id;
        msAddress = addr;
        msData    = data;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_in = 1'b1;
        msValid = 0; msWrite = 0; msID = '0; msAddress = '0; msData = '0;
        smTaken = 0; arready = 0; awready = 0; wready = 0;
        rvalid = 0; rid = '0; rdata = '0; rresp = 2'd0; rlast = 1'b1;
        bvalid = 0; bid = '0; bresp = 2'd0; err_clr = 0;

        // reset state
        @(negedge clk_in); @(negedge clk_in); #1;
        chk("rst_idle", idle, 1);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_smvalid", smValid, 0);
        chk("rst_mstaken", msTaken, 0);
        chk("rst_errs", {rd_err, wr_err, proto_err}, 0);
        chk("rst_bready", bready, 1);
        @(negedge clk_in); rst_in = 1'b0;

        // single read
        @(negedge clk_in); bus_req(0, 8'd5, 30'h10, 24'h0); #1;
        chk("rd1_taken", msTaken, 1);
        chk("rd1_no_ar_yet", arvalid, 0);
        @(negedge clk_in); msValid = 0; arready = 1; #1;
        chk("rd1_arvalid", arvalid, 1);
        chk("rd1_araddr", araddr, 32'h40);
        chk("rd1_arid", arid, 5);
        chk("rd1_arsize", arsize, 2);
        chk("rd1_arlen", arlen, 0);
        chk("rd1_arburst", arburst, 1);
        chk("rd1_busy", idle, 0);
        @(negedge clk_in); arready = 0;
        rvalid = 1; rid = 6'd5; rdata = 32'h00ABCDEF; rresp = 0; rlast = 1; #1;
        chk("rd1_ar_dropped", arvalid, 0);
        chk("rd1_rready", rready, 1);
        chk("rd1_sm_not_yet", smValid, 0);
        @(negedge clk_in); rvalid = 0; smTaken = 1; #1;
        chk("rd1_smvalid", smValid, 1);
        chk("rd1_smdata", smData, 24'hABCDEF);
        chk("rd1_smid", smID, 5);
        @(negedge clk_in); smTaken = 0; #1;
        chk("rd1_sm_done", smValid, 0);
        chk("rd1_idle", idle, 1);

        // write with AW held off three cycles, read queued behind it
        @(negedge clk_in); bus_req(1, 8'd3, 30'h20, 24'h123456); #1;
        chk("wr_taken", msTaken, 1);
        @(negedge clk_in); bus_req(0, 8'd7, 30'h30, 24'h0); wready = 1; awready = 0; #1;
        chk("wr_rd2_taken", msTaken, 1);
        chk("wr_awvalid0", awvalid, 1);
        chk("wr_wvalid0", wvalid, 1);
        chk("wr_awaddr", awaddr, 32'h80);
        chk("wr_awid", awid, 3);
        chk("wr_wid", wid, 3);
        chk("wr_wdata", wdata, 32'h00123456);
        chk("wr_wstrb", wstrb, 4'hF);
        chk("wr_wlast", wlast, 1);
        chk("wr_no_ar0", arvalid, 0);
        @(negedge clk_in); msValid = 0; #1;
        chk("wr_w_dropped", wvalid, 0);
        chk("wr_aw_held1", awvalid, 1);
        chk("wr_no_ar1", arvalid, 0);
        chk("wr_state_wait_aw", dbg_issue_state, 1);
        @(negedge clk_in); #1;
        chk("wr_aw_held2", awvalid, 1);
        chk("wr_no_ar2", arvalid, 0);
        @(negedge clk_in); awready = 1; #1;
        chk("wr_aw_held3", awvalid, 1);
        @(negedge clk_in); awready = 0; wready = 0; arready = 1; #1;
        chk("wr_aw_dropped", awvalid, 0);
        chk("wr_w_still_low", wvalid, 0);
        chk("wr_next_ar", arvalid, 1);
        chk("wr_next_arid", arid, 7);
        chk("wr_next_araddr", araddr, 32'hC0);
        chk("wr_state_fresh", dbg_issue_state, 0);
        @(negedge clk_in); arready = 0; bvalid = 1; bresp = 0; #1;
        chk("wr_ar_popped", arvalid, 0);
        @(negedge clk_in); bvalid = 0; rvalid = 1; rid = 6'd7; rdata = 32'h55; #1;
        @(negedge clk_in); rvalid = 0; smTaken = 1; #1;
        chk("wr_rd2_smid", smID, 7);
        chk("wr_rd2_smdata", smData, 24'h55);
        @(negedge clk_in); smTaken = 0; #1;
        chk("wr_idle", idle, 1);
        chk("wr_no_err", {wr_err, proto_err}, 0);

        // read credit limit: nine reads, eight accepted
        arready = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_in); bus_req(0, 8'(i), 30'(32'h100 + i), 24'h0); #1;
            chk($sformatf("credit_take_%0d", i), msTaken, (i < 8) ? 1 : 0);
        end
        @(negedge clk_in); #1;
        chk("credit_still_blocked", msTaken, 0);
        chk("credit_ar_drained", arvalid, 0);
        msValid = 0; arready = 0;

        // eight R beats with smTaken low fill the response FIFO
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            rvalid = 1; rid = 6'(i); rdata = 32'hFF000100 + i; rresp = 0; rlast = 1; #1;
            chk($sformatf("rsp_rready_%0d", i), rready, 1);
        end
        @(negedge clk_in); rvalid = 0; bus_req(0, 8'd9, 30'h1, 24'h0); #1;
        chk("rsp_full_rready", rready, 0);
        chk("rsp_full_smvalid", smValid, 1);
        chk("rsp_full_blocked", msTaken, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in); msValid = 0; smTaken = 1; #1;
            chk($sformatf("drain_valid_%0d", i), smValid, 1);
            chk($sformatf("drain_id_%0d", i), smID, i);
            chk($sformatf("drain_data_%0d", i), smData, 24'h000100 + i);
        end
        @(negedge clk_in); smTaken = 0; #1;
        chk("drain_empty", smValid, 0);
        chk("drain_rready", rready, 1);
        chk("drain_idle", idle, 1);

        // write error: sticky, cleared, set beats clear
        @(negedge clk_in); bus_req(1, 8'd2, 30'h2, 24'hA5A5A5); awready = 1; wready = 1; #1;
        chk("werr_taken", msTaken, 1);
        @(negedge clk_in); msValid = 0; #1;
        chk("werr_aw_same", awvalid, 1);
        chk("werr_w_same", wvalid, 1);
        @(negedge clk_in); bvalid = 1; bresp = 2'd2; #1;
        chk("werr_aw_popped", awvalid, 0);
        chk("werr_w_popped", wvalid, 0);
        chk("werr_pre", wr_err, 0);
        @(negedge clk_in); bvalid = 0; bresp = 0; #1;
        chk("werr_set", wr_err, 1);
        chk("werr_idle", idle, 1);
        @(negedge clk_in); #1;
        chk("werr_sticky", wr_err, 1);
        err_clr = 1;
        @(negedge clk_in); err_clr = 0; bus_req(1, 8'd4, 30'h3, 24'h1); #1;
        chk("werr_cleared", wr_err, 0);
        chk("werr2_taken", msTaken, 1);
        @(negedge clk_in); msValid = 0; #1;
        @(negedge clk_in); bvalid = 1; bresp = 2'd3; err_clr = 1; #1;
        @(negedge clk_in); bvalid = 0; bresp = 0; err_clr = 0; #1;
        chk("werr_set_beats_clr", wr_err, 1);
        err_clr = 1;
        @(negedge clk_in); err_clr = 0; #1;
        chk("werr_cleared2", wr_err, 0);
        awready = 0; wready = 0;

        // read error with rlast low, ID truncation, data still forwarded
        arready = 1;
        @(negedge clk_in); bus_req(0, 8'hC9, 30'h3FFFFFFF, 24'h0); #1;
        chk("rerr_taken", msTaken, 1);
        @(negedge clk_in); msValid = 0; #1;
        chk("rerr_arvalid", arvalid, 1);
        chk("rerr_arid_trunc", arid, 6'h09);
        chk("rerr_araddr", araddr, 32'hFFFFFFFC);
        @(negedge clk_in); arready = 0;
        rvalid = 1; rid = 6'h09; rdata = 32'hFFFFFFFF; rresp = 2'd2; rlast = 0; #1;
        @(negedge clk_in); rvalid = 0; rresp = 0; rlast = 1; smTaken = 1; #1;
        chk("rerr_smvalid", smValid, 1);
        chk("rerr_smdata", smData, 24'hFFFFFF);
        chk("rerr_smid", smID, 8'h09);
        chk("rerr_rd_err", rd_err, 1);
        chk("rerr_proto_err", proto_err, 1);
        chk("rerr_no_wr_err", wr_err, 0);
        @(negedge clk_in); smTaken = 0; err_clr = 1; #1;
        chk("rerr_idle", idle, 1);
        @(negedge clk_in); err_clr = 0; bvalid = 1; bresp = 0; #1;
        chk("rerr_cleared", {rd_err, proto_err}, 0);
        @(negedge clk_in); bvalid = 0; #1;
        chk("orphan_b_proto", proto_err, 1);
        chk("orphan_b_no_wr_err", wr_err, 0);
        chk("orphan_b_idle", idle, 1);
        err_clr = 1;
        @(negedge clk_in); err_clr = 0; #1;
        chk("orphan_cleared", proto_err, 0);

        // reset in the middle of a write
        @(negedge clk_in); bus_req(1, 8'd1, 30'h4, 24'h7); #1;
        chk("mrst_wr_taken", msTaken, 1);
        @(negedge clk_in); bus_req(0, 8'd2, 30'h5, 24'h0); #1;
        chk("mrst_rd_taken", msTaken, 1);
        chk("mrst_awvalid", awvalid, 1);
        @(negedge clk_in); msValid = 0; #1;
        chk("mrst_aw_pending", awvalid, 1);
        chk("mrst_busy", idle, 0);
        #2 rst_in = 1'b1; #1;
        chk("mrst_awvalid_async", awvalid, 0);
        chk("mrst_wvalid_async", wvalid, 0);
        chk("mrst_arvalid_async", arvalid, 0);
        chk("mrst_idle_async", idle, 1);
        @(negedge clk_in); rst_in = 1'b0; #1;
        chk("mrst_idle_after", idle, 1);
        chk("mrst_state", dbg_issue_state, 0);
        chk("mrst_errs", {rd_err, wr_err, proto_err}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
